// File: rtl/lab_access_pkg.sv
// Shared encodings for the multi-lab access controller.
// Optional ACCESS_STATS_EN adds per-lab denial counters in the top level.
package lab_access_pkg;

  localparam logic [1:0] MODE_EXIT  = 2'b00;
  localparam logic [1:0] MODE_ENTER = 2'b01;

  typedef enum logic [1:0] {
    DENY_FULL     = 2'b00,
    DENY_RESTRICT = 2'b01,
    DENY_EMPTY    = 2'b10,
    DENY_BADLAB   = 2'b11
  } deny_code_t;

endpackage

// File: rtl/lab_door_timer.sv
// Per-lab door hold timer: OPEN for UNLOCK_CYC cycles after the last load.
// Macro ACCESS_STATS_EN does not affect this block.
module lab_door_timer #(
  parameter int UNLOCK_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic unlock
);

  localparam int RW = $clog2(UNLOCK_CYC + 1);

  typedef enum logic {LOCKED, OPEN} door_e;

  door_e          st_q;
  logic [RW-1:0]  rem_q;
  logic           unlock_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= LOCKED;
      rem_q    <= '0;
      unlock_q <= 1'b0;
    end else if (load) begin
      st_q     <= OPEN;
      rem_q    <= RW'(UNLOCK_CYC);
      unlock_q <= 1'b1;
    end else if (st_q == OPEN) begin
      if (rem_q == RW'(1)) begin
        st_q     <= LOCKED;
        rem_q    <= '0;
        unlock_q <= 1'b0;
      end else begin
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  assign unlock = unlock_q;

endmodule

// File: rtl/lab_access_ctrl.sv
// N-lab occupancy and door controller with parity-restricted admission.
// Define ACCESS_STATS_EN to add the per-lab deniedCnt output.
module lab_access_ctrl
  import lab_access_pkg::*;
#(
  parameter int NUM_LABS    = 4,
  parameter int CAP         = 30,
  parameter int RESTRICT_TH = 15,
  parameter int CODE_W      = 5,
  parameter logic [NUM_LABS-1:0] PARITY_ODD = NUM_LABS'('b1010),
  parameter int UNLOCK_CYC  = 4,
  parameter int LAB_W = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1,
  parameter int CNT_W = $clog2(CAP + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CODE_W-1:0]         smartCode,
  input  logic [LAB_W-1:0]          lab,
  input  logic [1:0]                mode,
  output logic [NUM_LABS*CNT_W-1:0] numOfStu,
  output logic [NUM_LABS-1:0]       isFull,
  output logic [NUM_LABS-1:0]       isEmpty,
  output logic [NUM_LABS-1:0]       unlock,
  output logic [NUM_LABS-1:0]       restrictionWarn,
  output logic                      deny,
  output logic [1:0]                denyCode
`ifdef ACCESS_STATS_EN
  ,
  output logic [NUM_LABS*8-1:0]     deniedCnt
`endif
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] TH_C  = CNT_W'(RESTRICT_TH);

  logic [CNT_W-1:0]    cnt_q [NUM_LABS];
  logic [NUM_LABS-1:0] full_q, empty_q, warn_q, load;
  logic                deny_q;
  deny_code_t          code_q;

  logic                req, bad, par;
  logic                admit, leave, wrn, dny;
  deny_code_t          dcode;
  logic [LAB_W-1:0]    sel;
  logic [CNT_W-1:0]    c;

  always_comb begin
    req   = ~mode[1];
    bad   = {1'b0, lab} >= (LAB_W+1)'(NUM_LABS);
    sel   = bad ? '0 : lab;
    c     = cnt_q[sel];
    par   = ^smartCode;
    admit = 1'b0;
    leave = 1'b0;
    wrn   = 1'b0;
    dny   = 1'b0;
    dcode = DENY_FULL;
    if (req) begin
      if (bad) begin
        dny   = 1'b1;
        dcode = DENY_BADLAB;
      end else if (mode == MODE_ENTER) begin
        if (c == CAP_C) begin
          dny   = 1'b1;
          dcode = DENY_FULL;
        end else if (c >= TH_C) begin
          if (par == PARITY_ODD[sel]) begin
            admit = 1'b1;
            wrn   = 1'b1;
          end else begin
            dny   = 1'b1;
            dcode = DENY_RESTRICT;
          end
        end else begin
          admit = 1'b1;
        end
      end else if (c == '0) begin
        dny   = 1'b1;
        dcode = DENY_EMPTY;
      end else begin
        leave = 1'b1;
      end
    end
  end

  // Flags are derived from the next count so they track numOfStu exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int l = 0; l < NUM_LABS; l++) cnt_q[l] <= '0;
      full_q  <= '0;
      empty_q <= '1;
      warn_q  <= '0;
      deny_q  <= 1'b0;
      code_q  <= DENY_FULL;
    end else begin
      warn_q <= '0;
      deny_q <= dny;
      if (dny) code_q <= dcode;
      if (admit) begin
        cnt_q[sel]   <= c + 1'b1;
        full_q[sel]  <= (c + 1'b1) == CAP_C;
        empty_q[sel] <= 1'b0;
        warn_q[sel]  <= wrn;
      end
      if (leave) begin
        cnt_q[sel]   <= c - 1'b1;
        full_q[sel]  <= 1'b0;
        empty_q[sel] <= (c - 1'b1) == '0;
      end
    end
  end

  for (genvar l = 0; l < NUM_LABS; l++) begin : g_lab
    assign numOfStu[l*CNT_W +: CNT_W] = cnt_q[l];
    assign load[l] = (admit | leave) && (sel == LAB_W'(l));

    lab_door_timer #(
      .UNLOCK_CYC (UNLOCK_CYC)
    ) u_door (
      .CLK    (CLK),
      .RST    (RST),
      .load   (load[l]),
      .unlock (unlock[l])
    );
  end

`ifdef ACCESS_STATS_EN
  logic [7:0] dcnt_q [NUM_LABS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int l = 0; l < NUM_LABS; l++) dcnt_q[l] <= '0;
    end else if (dny && !bad && dcnt_q[sel] != 8'hFF) begin
      dcnt_q[sel] <= dcnt_q[sel] + 8'd1;
    end
  end

  for (genvar l = 0; l < NUM_LABS; l++) begin : g_stat
    assign deniedCnt[l*8 +: 8] = dcnt_q[l];
  end
`endif

  assign isFull          = full_q;
  assign isEmpty         = empty_q;
  assign restrictionWarn = warn_q;
  assign deny            = deny_q;
  assign denyCode        = code_q;

endmodule

// File: tb/tb_lab_access_ctrl.sv
// Scoreboard bench for lab_access_ctrl; ACCESS_STATS_EN enables
// the deniedCnt checks.
module tb_lab_access_ctrl;

  localparam int NL  = 4;
  localparam int CW  = 5;
  localparam int CAP = 30;
  localparam int TH  = 15;
  localparam int UC  = 4;
  localparam logic [3:0] PAR = 4'b1010;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [4:0]    smartCode = '0;
  logic [1:0]    lab = '0;
  logic [1:0]    mode = 2'b10;
  logic [NL*CW-1:0] numOfStu;
  logic [NL-1:0] isFull, isEmpty, unlock, restrictionWarn;
  logic          deny;
  logic [1:0]    denyCode;
  logic [14:0]   numOfStu3;
  logic [2:0]    isFull3, isEmpty3, unlock3, warn3;
  logic          deny3;
  logic [1:0]    denyCode3;
`ifdef ACCESS_STATS_EN
  logic [NL*8-1:0] deniedCnt;
  logic [23:0]     deniedCnt3;
`endif

  always #5 CLK = ~CLK;

  lab_access_ctrl u_dut (
    .CLK             (CLK),
    .RST             (RST),
    .smartCode       (smartCode),
    .lab             (lab),
    .mode            (mode),
    .numOfStu        (numOfStu),
    .isFull          (isFull),
    .isEmpty         (isEmpty),
    .unlock          (unlock),
    .restrictionWarn (restrictionWarn),
    .deny            (deny),
    .denyCode        (denyCode)
`ifdef ACCESS_STATS_EN
    ,
    .deniedCnt       (deniedCnt)
`endif
  );

  // Three-lab instance so that lab index 3 is out of range.
  lab_access_ctrl #(.NUM_LABS(3)) u_dut3 (
    .CLK             (CLK),
    .RST             (RST),
    .smartCode       (smartCode),
    .lab             (lab),
    .mode            (mode),
    .numOfStu        (numOfStu3),
    .isFull          (isFull3),
    .isEmpty         (isEmpty3),
    .unlock          (unlock3),
    .restrictionWarn (warn3),
    .deny            (deny3),
    .denyCode        (denyCode3)
`ifdef ACCESS_STATS_EN
    ,
    .deniedCnt       (deniedCnt3)
`endif
  );

  typedef struct packed {
    logic [NL*CW-1:0] cnt;
    logic [NL-1:0]    full;
    logic [NL-1:0]    empty;
    logic [NL-1:0]    unl;
    logic [NL-1:0]    warn;
    logic             dny;
    logic [1:0]       dc;
    logic [NL*8-1:0]  dcnt;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         m_cnt [NL];
  int         m_rem [NL];
  int         m_dc  [NL];
  logic [1:0] m_code = 2'b00;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic [1:0] m,
                       input logic [1:0] l, input logic [4:0] code,
                       output exp_t e);
    logic [NL-1:0] ld;
    logic [NL-1:0] w;
    logic          d;
    ld = '0;
    w  = '0;
    d  = 1'b0;
    if (r) begin
      for (int i = 0; i < NL; i++) begin
        m_cnt[i] = 0;
        m_rem[i] = 0;
        m_dc[i]  = 0;
      end
      m_code = 2'b00;
    end else begin
      if (!m[1]) begin
        if (m == 2'b01) begin
          if (m_cnt[l] == CAP) begin
            d = 1'b1; m_code = 2'b00;
          end else if (m_cnt[l] >= TH) begin
            if ((^code) == PAR[l]) begin
              m_cnt[l]++; ld[l] = 1'b1; w[l] = 1'b1;
            end else begin
              d = 1'b1; m_code = 2'b01;
            end
          end else begin
            m_cnt[l]++; ld[l] = 1'b1;
          end
        end else if (m_cnt[l] == 0) begin
          d = 1'b1; m_code = 2'b10;
        end else begin
          m_cnt[l]--; ld[l] = 1'b1;
        end
        if (d && m_dc[l] < 255) m_dc[l]++;
      end
      for (int i = 0; i < NL; i++) begin
        if (ld[i]) m_rem[i] = UC;
        else if (m_rem[i] > 0) m_rem[i]--;
      end
    end
    for (int i = 0; i < NL; i++) begin
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
      e.full[i]  = (m_cnt[i] == CAP);
      e.empty[i] = (m_cnt[i] == 0);
      e.unl[i]   = (m_rem[i] > 0);
      e.dcnt[i*8 +: 8] = 8'(m_dc[i]);
    end
    e.warn = w;
    e.dny  = d;
    e.dc   = m_code;
  endtask

  task automatic step(input logic r, input logic [1:0] m,
                      input logic [1:0] l, input logic [4:0] code);
    exp_t e;
    @(negedge CLK);
    RST = r; mode = m; lab = l; smartCode = code;
    model(r, m, l, code, e);
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk("numOfStu", 64'(numOfStu), 64'(e.cnt));
    chk("isFull", 64'(isFull), 64'(e.full));
    chk("isEmpty", 64'(isEmpty), 64'(e.empty));
    chk("unlock", 64'(unlock), 64'(e.unl));
    chk("restrictionWarn", 64'(restrictionWarn), 64'(e.warn));
    chk("deny", 64'(deny), 64'(e.dny));
    chk("denyCode", 64'(denyCode), 64'(e.dc));
`ifdef ACCESS_STATS_EN
    chk("deniedCnt", 64'(deniedCnt), 64'(e.dcnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 2'd0, 5'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 2'b10, 2'd0, 5'd0);
    chk("rst_empty", 64'(isEmpty), 64'hF);

    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 2'd2, 5'($urandom));
    chk("lab2_cnt", 64'(numOfStu[2*CW +: CW]), 64'd3);
    idle(6);

    for (int i = 0; i < 15; i++) step(1'b0, 2'b01, 2'd1, 5'($urandom));
    step(1'b0, 2'b01, 2'd1, 5'b00011);
    chk("restrict_code", 64'(denyCode), 64'd1);
    step(1'b0, 2'b01, 2'd1, 5'b00111);
    chk("restrict_warn", 64'(restrictionWarn), 64'b0010);
    step(1'b0, 2'b01, 2'd1, 5'b10101);

    for (int i = 0; i < 30; i++)
      step(1'b0, 2'b01, 2'd0, (i >= 15) ? 5'b00011 : 5'($urandom));
    chk("lab0_full", 64'(isFull[0]), 64'd1);
    step(1'b0, 2'b01, 2'd0, 5'b00011);
    step(1'b0, 2'b01, 2'd0, 5'b00011);

    step(1'b0, 2'b00, 2'd3, 5'd0);
    chk("empty_code", 64'(denyCode), 64'd2);
    step(1'b0, 2'b00, 2'd1, 5'd0);
    chk("badlab3_deny", 64'(deny3), 64'd0);
    step(1'b0, 2'b01, 2'd3, 5'd1);
    chk("badlab3_deny", 64'(deny3), 64'd1);
    chk("badlab3_code", 64'(denyCode3), 64'd3);
    step(1'b0, 2'b00, 2'd3, 5'd1);
    chk("badlab3_code", 64'(denyCode3), 64'd3);
    idle(5);

    step(1'b1, 2'b10, 2'd0, 5'd0);
    step(1'b0, 2'b01, 2'd0, 5'd0);
    step(1'b0, 2'b10, 2'd0, 5'd0);
    step(1'b0, 2'b01, 2'd0, 5'd0);
    step(1'b1, 2'b01, 2'd0, 5'd0);
    chk("rst_unlock", 64'(unlock), 64'd0);
    step(1'b0, 2'b01, 2'd0, 5'd0);
    step(1'b0, 2'b10, 2'd0, 5'd0);
    step(1'b0, 2'b01, 2'd0, 5'd0);
    idle(7);

    for (int i = 0; i < 250; i++)
      step(($urandom_range(0, 99) == 0),
           2'($urandom_range(0, 3) == 3 ? 2 : $urandom_range(0, 1) + (i % 7 < 5 ? 1 : 0) - 1 + 0) == 2'b11 ? 2'b01 : 2'($urandom_range(0, 2)),
           2'($urandom), 5'($urandom));

    for (int i = 0; i < 40; i++)
      step(1'b0, 2'b01, 2'($urandom_range(1, 2)), 5'($urandom));
    for (int i = 0; i < 20; i++)
      step(1'b0, 2'($urandom_range(0, 1)), 2'($urandom), 5'($urandom));

`ifdef ACCESS_STATS_EN
    step(1'b1, 2'b10, 2'd0, 5'd0);
    for (int i = 0; i < 30; i++) step(1'b0, 2'b01, 2'd0, 5'b00011);
    for (int i = 0; i < 300; i++) step(1'b0, 2'b01, 2'd0, 5'b00011);
    chk("stats_sat", 64'(deniedCnt[7:0]), 64'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
